// File: rtl/twi_pkg.sv
// ---------------------------------------------------------------------------
// twi_pkg : shared command, state and quarter-index definitions
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package twi_pkg;

   typedef enum logic [2:0] {
      CMD_NOP       = 3'd0,
      CMD_START     = 3'd1,
      CMD_STOP      = 3'd2,
      CMD_WRITE     = 3'd3,
      CMD_READ_ACK  = 3'd4,
      CMD_READ_NACK = 3'd5
   } twi_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BIT   = 3'd2,
      ST_STOP  = 3'd3,
      ST_DONE  = 3'd4
   } twi_state_t;

   localparam logic [1:0] Q_START = 2'd0;
   localparam logic [1:0] Q_HIGH0 = 2'd1;
   localparam logic [1:0] Q_HIGH1 = 2'd2;
   localparam logic [1:0] Q_END   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/twi_tick_gen.sv
// ---------------------------------------------------------------------------
// twi_tick_gen : quarter-bit counter, pulses tick every CLK_DIV enabled clocks
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module twi_tick_gen #(
   parameter int CLK_DIV = 125
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;

   assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear || !en) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/twi_master_engine.sv
// ---------------------------------------------------------------------------
// twi_master_engine : one-command-at-a-time TWI master byte engine (open drain)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module twi_master_engine
   import twi_pkg::*;
#(
   parameter int CLK_DIV = 125
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid_i,
   input  logic [2:0] cmd_i,
   input  logic [7:0] cmd_data_i,
   output logic       cmd_ready_o,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_data_o,
   output logic       rsp_ack_o,
   output logic       scl_oe_o,
   output logic       sda_oe_o,
   input  logic       sda_i
);

   twi_state_t state_q, state_d;
   twi_cmd_t   op_q, op_d;
   logic [1:0] q_q, q_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       scl_q, scl_d;
   logic       sda_q, sda_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_ack_q, rsp_ack_d;

   logic       busy;
   logic       tick;
   logic       bit_oe;
   logic       last_bit;

   assign busy     = (state_q == ST_START) || (state_q == ST_BIT) || (state_q == ST_STOP);
   assign last_bit = (bit_cnt_q == 4'd8);

   // Bits 0..7 drive the write data (reads release SDA); bit 8 is the ACK slot.
   assign bit_oe = last_bit ? (op_q == CMD_READ_ACK)
                            : ((op_q == CMD_WRITE) && !shift_q[7]);

   twi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy),
      .clear (!busy),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= CMD_NOP;
         q_q         <= Q_START;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         scl_q       <= 1'b0;
         sda_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         q_q         <= q_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_ack_q   <= rsp_ack_d;
      end
   end

   // Each tick applies the line action of the quarter that is ending.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      q_d         = q_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      scl_d       = scl_q;
      sda_d       = sda_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_ack_d   = rsp_ack_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               op_d      = twi_cmd_t'(cmd_i);
               q_d       = Q_START;
               bit_cnt_d = '0;
               shift_d   = cmd_data_i;
               case (twi_cmd_t'(cmd_i))
                  CMD_START:     state_d = ST_START;
                  CMD_STOP:      state_d = ST_STOP;
                  CMD_WRITE,
                  CMD_READ_ACK,
                  CMD_READ_NACK: state_d = ST_BIT;
                  default:       state_d = ST_DONE;
               endcase
            end
         end

         ST_START: begin
            if (tick) begin
               q_d = q_q + 2'd1;
               case (q_q)
                  Q_START: sda_d = 1'b0;
                  Q_HIGH0: scl_d = 1'b0;
                  Q_HIGH1: sda_d = 1'b1;
                  default: begin
                     scl_d   = 1'b1;
                     state_d = ST_DONE;
                  end
               endcase
            end
         end

         ST_STOP: begin
            if (tick) begin
               q_d = q_q + 2'd1;
               case (q_q)
                  Q_START: begin
                     scl_d = 1'b1;
                     sda_d = 1'b1;
                  end
                  Q_HIGH0: scl_d = 1'b0;
                  Q_HIGH1: sda_d = 1'b0;
                  default: state_d = ST_DONE;
               endcase
            end
         end

         ST_BIT: begin
            if (tick) begin
               q_d = q_q + 2'd1;
               case (q_q)
                  Q_START: begin
                     scl_d = 1'b1;
                     sda_d = bit_oe;
                  end
                  Q_HIGH0: scl_d = 1'b0;
                  Q_HIGH1: begin
                     scl_d = 1'b0;
                     if (!last_bit) begin
                        shift_d = {shift_q[6:0], sda_i};
                     end else if (op_q == CMD_WRITE) begin
                        rsp_ack_d = !sda_i;
                     end
                  end
                  default: begin
                     scl_d = 1'b1;
                     if (last_bit) begin
                        state_d = ST_DONE;
                     end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                     end
                  end
               endcase
            end
         end

         ST_DONE: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            if ((op_q == CMD_READ_ACK) || (op_q == CMD_READ_NACK)) begin
               rsp_data_d = shift_q;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_ack_o   = rsp_ack_q;
   assign scl_oe_o    = scl_q;
   assign sda_oe_o    = sda_q;

endmodule

`default_nettype wire

// File: tb/tb_twi_master_engine.sv
// ---------------------------------------------------------------------------
// tb_twi_master_engine : directed self-checking bench for twi_master_engine
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_twi_master_engine;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid_i = 1'b0;
   logic [2:0] cmd_i = 3'd0;
   logic [7:0] cmd_data_i = 8'h00;
   logic       sda_i = 1'b1;
   logic       cmd_ready_o;
   logic       rsp_valid_o;
   logic [7:0] rsp_data_o;
   logic       rsp_ack_o;
   logic       scl_oe_o;
   logic       sda_oe_o;

   int         compared = 0;
   int         mismatched = 0;
   int         rsp_cyc;
   int         rsp_cnt;
   logic [8:0] sda_obs;
   logic       b9_or;
   logic       b9_and;
   logic       line_changed;

   twi_master_engine #(
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid_i (cmd_valid_i),
      .cmd_i       (cmd_i),
      .cmd_data_i  (cmd_data_i),
      .cmd_ready_o (cmd_ready_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_ack_o   (rsp_ack_o),
      .scl_oe_o    (scl_oe_o),
      .sda_oe_o    (sda_oe_o),
      .sda_i       (sda_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one command (acceptance edge = cycle 0) and watches it to completion.
   // bits[8] is presented on sda_i for bit 0 ... bits[0] for bit 8.
   task automatic run_cmd(input logic [2:0] c, input logic [7:0] d,
                          input logic [8:0] bits, input int busy_at);
      logic scl0, sda0;
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_i       = c;
      cmd_data_i  = d;
      @(posedge clk);
      #1;
      cmd_valid_i  = 1'b0;
      cmd_i        = 3'd0;
      scl0         = scl_oe_o;
      sda0         = sda_oe_o;
      rsp_cyc      = 0;
      rsp_cnt      = 0;
      sda_obs      = '0;
      b9_or        = 1'b0;
      b9_and       = 1'b1;
      line_changed = 1'b0;
      for (int n = 1; n <= 170; n++) begin
         @(posedge clk);
         #1;
         if (rsp_valid_o === 1'b1) begin
            rsp_cnt++;
            if (rsp_cyc == 0) rsp_cyc = n;
         end
         if ((scl_oe_o !== scl0) || (sda_oe_o !== sda0)) line_changed = 1'b1;
         for (int k = 0; k < 9; k++) begin
            if (n == 16 * k + 6)  sda_i = bits[8-k];
            if (n == 16 * k + 10) sda_obs[8-k] = sda_oe_o;
         end
         if (n >= 133 && n <= 144) begin
            b9_or  = b9_or | sda_oe_o;
            b9_and = b9_and & sda_oe_o;
         end
         if (busy_at != 0 && n == busy_at) begin
            cmd_valid_i = 1'b1;
            cmd_i       = 3'd3;
            cmd_data_i  = 8'hFF;
         end
         if (busy_at != 0 && n == busy_at + 1) begin
            cmd_valid_i = 1'b0;
            cmd_i       = 3'd0;
         end
         if (rsp_cyc != 0 && n >= rsp_cyc + 3) break;
      end
      sda_i = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_scl", 32'(scl_oe_o), 0);
      check("reset_sda", 32'(sda_oe_o), 0);
      check("reset_ready", 32'(cmd_ready_o), 1);
      check("reset_rsp_valid", 32'(rsp_valid_o), 0);
      check("reset_rsp_data", 32'(rsp_data_o), 32'h00);
      check("reset_rsp_ack", 32'(rsp_ack_o), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_cmd(3'd1, 8'h00, 9'h1FF, 0);
      check("start_rsp_cycle", 32'(rsp_cyc), 17);
      check("start_rsp_count", 32'(rsp_cnt), 1);
      check("start_scl_end", 32'(scl_oe_o), 1);
      check("start_sda_end", 32'(sda_oe_o), 1);

      run_cmd(3'd3, 8'hA5, 9'h1FE, 0);
      check("wr_a5_sda_bits", 32'(sda_obs), 32'h0B4);
      check("wr_a5_rsp_cycle", 32'(rsp_cyc), 145);
      check("wr_a5_ack", 32'(rsp_ack_o), 1);
      check("wr_a5_rsp_data", 32'(rsp_data_o), 32'h00);
      check("wr_a5_ready", 32'(cmd_ready_o), 1);

      run_cmd(3'd3, 8'h00, 9'h1FF, 0);
      check("wr_00_sda_bits", 32'(sda_obs), 32'h1FE);
      check("wr_00_rsp_cycle", 32'(rsp_cyc), 145);
      check("wr_00_nack", 32'(rsp_ack_o), 0);
      check("wr_00_rsp_data", 32'(rsp_data_o), 32'h00);

      run_cmd(3'd5, 8'h00, 9'h079, 0);
      check("rdn_sda_bits", 32'(sda_obs), 32'h000);
      check("rdn_rsp_cycle", 32'(rsp_cyc), 145);
      check("rdn_rsp_data", 32'(rsp_data_o), 32'h3C);
      check("rdn_bit9_sda", 32'(b9_or), 0);
      check("rdn_ack_kept", 32'(rsp_ack_o), 0);

      run_cmd(3'd2, 8'h00, 9'h1FF, 0);
      check("stop_rsp_cycle", 32'(rsp_cyc), 17);
      check("stop_scl_end", 32'(scl_oe_o), 0);
      check("stop_sda_end", 32'(sda_oe_o), 0);

      run_cmd(3'd4, 8'h00, 9'h187, 50);
      check("rda_rsp_cycle", 32'(rsp_cyc), 145);
      check("rda_rsp_count", 32'(rsp_cnt), 1);
      check("rda_rsp_data", 32'(rsp_data_o), 32'hC3);
      check("rda_bit9_sda", 32'(b9_and), 1);
      check("rda_ready_after", 32'(cmd_ready_o), 1);

      run_cmd(3'd7, 8'h55, 9'h1FF, 0);
      check("nop_rsp_cycle", 32'(rsp_cyc), 1);
      check("nop_rsp_count", 32'(rsp_cnt), 1);
      check("nop_lines_quiet", 32'(line_changed), 0);
      check("nop_rsp_data", 32'(rsp_data_o), 32'hC3);

      // Reset in the middle of bit 3 of a WRITE of A5 (that bit drives SDA low).
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_i       = 3'd3;
      cmd_data_i  = 8'hA5;
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      cmd_i       = 3'd0;
      repeat (52) @(posedge clk);
      #1;
      check("midrst_pre_scl", 32'(scl_oe_o), 1);
      check("midrst_pre_sda", 32'(sda_oe_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_scl", 32'(scl_oe_o), 0);
      check("midrst_sda", 32'(sda_oe_o), 0);
      check("midrst_ready", 32'(cmd_ready_o), 1);
      check("midrst_rsp_valid", 32'(rsp_valid_o), 0);
      check("midrst_rsp_data", 32'(rsp_data_o), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_cmd(3'd1, 8'h00, 9'h1FF, 0);
      check("post_rst_start_cycle", 32'(rsp_cyc), 17);
      check("post_rst_start_count", 32'(rsp_cnt), 1);
      check("post_rst_start_scl", 32'(scl_oe_o), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/twi_master_engine.md
# twi_master_engine

Single-clock TWI (I2C) master byte engine for the TWI clock domain of the SchoolMIPS TWI peripheral. It takes one command at a time, either START, STOP, WRITE byte or READ byte. It drives open-drain SCL/SDA through output-enable pins and returns one response per command. Its command input is fed from the byte mailbox output on the TWI side, and its responses are written back into that mailbox.

## Interface
- CLK_DIV, 125, system clocks per quarter SCL bit period; legal range ≥ 2.
- clk  input  1  system clock; every register is updated on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command strobe.
- cmd  input  3  command code: 0 NOP, 1 START, 2 STOP, 3 WRITE, 4 READ_ACK, 5 READ_NACK; codes 6–7 behave as NOP.
- cmd_data  input  8  byte to transmit; used by WRITE only.
- cmd_ready  output  1  engine idle; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_data  output  8  received byte; updated only by READ commands.
- rsp_ack  output  1  slave ACK from the last WRITE (1 = ACK, i.e. SDA sampled low); updated only by WRITE commands.
- scl_oe  output  1  1 = pull SCL low, 0 = release SCL.
- sda_oe  output  1  1 = pull SDA low, 0 = release SDA.
- sda_i  input  1  SDA line state; already synchronised.

## Operation
- **Reset values:** scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=8'h00, rsp_ack=0. The FSM is in IDLE and the quarter counter is 0.
- **FSM states:** IDLE, START, BIT, STOP, DONE.
  - IDLE: accepting a command moves to START, STOP or BIT according to cmd; NOP goes straight to DONE.
  - BIT returns to itself until all 9 bits are done, then goes to DONE.
  - DONE always returns to IDLE.
- **Quarter tick:** the counter runs 0..CLK_DIV-1 only outside IDLE/DONE. The tick fires when count = CLK_DIV-1. A 2-bit quarter index q advances on each tick.
- **START sequence** (valid from bus idle and as a repeated start):
  - q0: sda_oe=0, scl_oe unchanged.
  - q1: scl_oe=0.
  - q2: sda_oe=1.
  - q3: scl_oe=1.
  - Ends with SCL low and SDA low.
- **Bit slot:**
  - q0: scl_oe=1, sda_oe = ~bit (released for receive bits).
  - q1, q2: scl_oe=0.
  - sda_i is sampled on the tick that ends q2.
  - q3: scl_oe=1.
- **WRITE:** 8 data bits are sent from cmd_data, MSB first. The 9th bit is sent with sda_oe=0, and rsp_ack = ~(sampled sda_i).
- **READ_ACK / READ_NACK:** 8 bits are received with sda_oe=0, shifted in MSB first, and rsp_data is loaded at DONE. The 9th bit drives sda_oe=1 for READ_ACK and sda_oe=0 for READ_NACK.
- **STOP sequence:**
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0.
  - q2: sda_oe=0.
  - q3: hold.
  - Ends with both lines released.
- **cmd_valid while busy:** ignored; the command is not queued.
- **Bus order is software's responsibility:** WRITE or READ issued without a preceding START is still executed.
- **Clock stretching:** not supported; the engine does not read SCL.

## Timing
- Cycle 0 is the acceptance edge. cmd_ready is 0 from cycle 1 until completion.
- **rsp_valid timing:** rsp_valid is high during exactly one cycle:
  - cycle 4·CLK_DIV+1 for START and STOP;
  - cycle 36·CLK_DIV+1 for WRITE and READ;
  - cycle 1 for NOP.
- cmd_ready returns to 1 in the same cycle as rsp_valid. The earliest next acceptance is that cycle's edge.
- scl_oe and sda_oe are registered outputs and change only on tick edges.
- **Async reset mid-command:** both lines are released immediately, and all outputs take their reset values. No partial response is produced.

## Structure
- Package twi_pkg holds:
  - typedef twi_cmd_t, an enum of the 3-bit codes above;
  - typedef twi_state_t, the FSM enum;
  - localparam Q_START=0, Q_HIGH0=1, Q_HIGH1=2, Q_END=3.
- Sub-module twi_tick_gen holds the quarter counter. It has parameter CLK_DIV, inputs en and clear, and output tick.
- The top level contains the FSM, a 4-bit bit counter (0..8), an 8-bit shift register, and the output registers.

## Test plan
All scenarios use CLK_DIV=4.
- **Reset:** assert rst=0 mid-run → scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=00 immediately, without waiting for a clock edge.
- **START, then WRITE with ACK:** START, then WRITE cmd_data=8'hA5 with sda_i held 0 in bit 9.
  - sda_oe per bit = 0,1,0,1,1,0,1,0, then 0 for bit 9.
  - START rsp_valid at cycle 17.
  - WRITE rsp_valid at cycle 145 with rsp_ack=1.
- **WRITE with NACK:** WRITE 8'h00 with sda_i held 1 → rsp_ack=0 and rsp_data unchanged.
- **READ_NACK then STOP:** READ_NACK with sda_i presenting 8'h3C MSB first → rsp_data=8'h3C at cycle 145 and sda_oe=0 throughout bit 9. A following STOP ends with scl_oe=0, sda_oe=0, and rsp_valid at cycle 17.
- **READ_ACK, busy command, illegal code:**
  - READ_ACK → sda_oe=1 during bit 9.
  - A WRITE pulsed during READ_ACK is ignored: no extra rsp_valid.
  - cmd=7 → rsp_valid at cycle 1 with no line activity.
- **Reset mid-WRITE:** rst=0 during bit 3 of a WRITE → both lines released at once. After rst=1, START is accepted and rsp_valid arrives at cycle 17.
